run_sequencer: RTL and testbench

- Top-level run controller for the 9-bit-instruction processor core.
- Sequences each program run through start handshake, data-memory clear, PC load, run, and completion or timeout.
- Drives the core's run gate, PC load, memory clear port and the ack/cycle-count outputs.
- Sits between the testbench start/ack pins and the program counter, register file, data memory and control decoder.

---
 rtl/run_sequencer_if.sv | 35 +++
 rtl/run_sequencer.sv | 163 ++++++++++++++++
 tb/tb_run_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/run_sequencer_if.sv
// run_sequencer_if: bundles the start/ack handshake with the core-side
// run controls (run gate, PC load, memory clear, counters).
// master = the sequencer; slave = the testbench / core side.
interface run_sequencer_if #(
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [1:0]        prog_sel;
  logic              done_instr;
  logic              branch_taken;
  logic              run_en;
  logic              pc_load;
  logic [PC_W-1:0]   pc_load_value;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              ack;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  instr_count;
  logic [CNT_W-1:0]  branch_count;

  modport master (
    input  start, prog_sel, done_instr, branch_taken,
    output run_en, pc_load, pc_load_value, clr_en, clr_addr,
           ack, timeout, cycle_count, instr_count, branch_count
  );

  modport slave (
    output start, prog_sel, done_instr, branch_taken,
    input  run_en, pc_load, pc_load_value, clr_en, clr_addr,
           ack, timeout, cycle_count, instr_count, branch_count
  );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: run controller for the 9-bit-instruction core.
// Sequence: IDLE -> ARMED (start high) -> CLEAR (data-memory zero sweep)
// -> LOAD (PC load pulse) -> RUN -> FINISH (ack, optional timeout).
// A start pulse during CLEAR/LOAD/RUN aborts the run back to ARMED.
// Optional macro RUN_SEQ_PERF_EN builds the instr_count/branch_count
// counters; without it both outputs read 0 and no counter flops exist.
module run_sequencer #(
  parameter int          PC_W        = 32,
  parameter int          CNT_W       = 16,
  parameter int          ADDR_W      = 8,
  parameter int          CLEAR_DEPTH = 256,
  parameter int          CYCLE_LIMIT = 4096,
  parameter logic [31:0] PROG_BASE_0 = 32'd0,
  parameter logic [31:0] PROG_BASE_1 = 32'd0,
  parameter logic [31:0] PROG_BASE_2 = 32'd0,
  parameter logic [31:0] PROG_BASE_3 = 32'd0
) (
  input logic             clk,
  input logic             reset,
  run_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    CLEAR  = 3'd2,
    LOAD   = 3'd3,
    RUN    = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Last sweep address; guarded so CLEAR_DEPTH=0 does not produce -1.
  localparam logic [ADDR_W-1:0] CLR_LAST =
    ADDR_W'((CLEAR_DEPTH > 0) ? (CLEAR_DEPTH - 1) : 0);
  // cycle_count value (pre-increment) in the last permitted RUN cycle.
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(CYCLE_LIMIT - 1);

  state_t            state_reg, state_next;
  logic [1:0]        sel_reg;
  logic [PC_W-1:0]   pc_value_reg;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic [CNT_W-1:0]  cycle_count_reg;
  logic              timeout_reg;
  logic              arm_entry;
  logic              limit_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state decode; abort (start high) has priority over done/limit.
  always_comb begin
    state_next = state_reg;
    limit_hit  = 1'b0;
    case (state_reg)
      IDLE:   if (bus.start) state_next = ARMED;
      ARMED:  if (!bus.start) state_next = (CLEAR_DEPTH > 0) ? CLEAR : LOAD;
      CLEAR: begin
        if (bus.start)                  state_next = ARMED;
        else if (clr_addr_reg == CLR_LAST) state_next = LOAD;
      end
      LOAD:   state_next = bus.start ? ARMED : RUN;
      RUN: begin
        if (bus.start) begin
          state_next = ARMED;
        end else if (bus.done_instr) begin
          state_next = FINISH;
        end else if (cycle_count_reg == LIMIT_LAST) begin
          state_next = FINISH;
          limit_hit  = 1'b1;
        end
      end
      FINISH: if (bus.start) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  assign arm_entry = (state_next == ARMED) && (state_reg != ARMED);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Program select is captured as ARMED is left; PC value is loaded on LOAD entry and then held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_reg      <= 2'd0;
      pc_value_reg <= '0;
    end else begin
      if (state_reg == ARMED && !bus.start) sel_reg <= bus.prog_sel;
      if (state_next == LOAD && state_reg != LOAD) begin
        // In the ARMED->LOAD path (no clear phase) the fresh select is used.
        case ((state_reg == ARMED) ? bus.prog_sel : sel_reg)
          2'd0:    pc_value_reg <= PC_W'(PROG_BASE_0);
          2'd1:    pc_value_reg <= PC_W'(PROG_BASE_1);
          2'd2:    pc_value_reg <= PC_W'(PROG_BASE_2);
          default: pc_value_reg <= PC_W'(PROG_BASE_3);
        endcase
      end
    end
  end

  // Clear-sweep address: zeroed on arming, steps during CLEAR, parks at the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                               clr_addr_reg <= '0;
    else if (arm_entry)                                       clr_addr_reg <= '0;
    else if (state_reg == CLEAR && clr_addr_reg != CLR_LAST)  clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
  end

  // Run cycle counter and timeout flag; both frozen outside RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count_reg <= '0;
      timeout_reg     <= 1'b0;
    end else if (arm_entry) begin
      cycle_count_reg <= '0;
      timeout_reg     <= 1'b0;
    end else if (state_reg == RUN) begin
      cycle_count_reg <= sat_inc(cycle_count_reg);
      if (limit_hit) timeout_reg <= 1'b1;
    end
  end

`ifdef RUN_SEQ_PERF_EN
  logic [CNT_W-1:0] instr_count_reg;
  logic [CNT_W-1:0] branch_count_reg;

  // Performance counters: every RUN cycle retires one instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count_reg  <= '0;
      branch_count_reg <= '0;
    end else if (arm_entry) begin
      instr_count_reg  <= '0;
      branch_count_reg <= '0;
    end else if (state_reg == RUN) begin
      instr_count_reg <= sat_inc(instr_count_reg);
      if (bus.branch_taken) branch_count_reg <= sat_inc(branch_count_reg);
    end
  end

  assign bus.instr_count  = instr_count_reg;
  assign bus.branch_count = branch_count_reg;
`else
  logic unused_branch_taken;
  assign unused_branch_taken = bus.branch_taken;
  assign bus.instr_count     = '0;
  assign bus.branch_count    = '0;
`endif

  // Strobes are pure state decodes, so they are mutually exclusive by construction.
  assign bus.clr_en        = (state_reg == CLEAR);
  assign bus.pc_load       = (state_reg == LOAD);
  assign bus.run_en        = (state_reg == RUN);
  assign bus.ack           = (state_reg == FINISH);
  assign bus.timeout       = timeout_reg;
  assign bus.clr_addr      = clr_addr_reg;
  assign bus.pc_load_value = pc_value_reg;
  assign bus.cycle_count   = cycle_count_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed test of run_sequencer with CLEAR_DEPTH=4,
// CYCLE_LIMIT=16, PROG_BASE_1=100, PROG_BASE_2=40. Inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_run_sequencer;
  localparam int PC_W = 32, CNT_W = 16, ADDR_W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  run_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  run_sequencer #(
    .PC_W(PC_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
    .CLEAR_DEPTH(4), .CYCLE_LIMIT(16),
    .PROG_BASE_0(32'd7), .PROG_BASE_1(32'd100),
    .PROG_BASE_2(32'd40), .PROG_BASE_3(32'd3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

`ifdef RUN_SEQ_PERF_EN
  localparam logic [31:0] EXP_INSTR = 32'd12, EXP_BR = 32'd3;
`else
  localparam logic [31:0] EXP_INSTR = 32'd0,  EXP_BR = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm with start held for 'hold' cycles, release with 'sel', verify
  // the 4-word sweep and the PC load; returns positioned on RUN cycle 1.
  task automatic start_run(input int hold, input logic [1:0] sel, input logic [31:0] base);
    bus.start = 1'b1;
    repeat (hold) tick();
    check("armed_ack", 32'(bus.ack), 32'd0);
    check("armed_timeout", 32'(bus.timeout), 32'd0);
    check("armed_cycles", 32'(bus.cycle_count), 32'd0);
    bus.start    = 1'b0;
    bus.prog_sel = sel;
    tick();
    bus.prog_sel = ~sel;  // must be ignored after latching
    for (int i = 0; i < 4; i++) begin
      check("clr_en", 32'(bus.clr_en), 32'd1);
      check("clr_addr", 32'(bus.clr_addr), 32'(i));
      check("clr_excl", 32'(bus.pc_load | bus.run_en), 32'd0);
      tick();
    end
    check("pc_load", 32'(bus.pc_load), 32'd1);
    check("pc_load_value", bus.pc_load_value, base);
    check("load_excl", 32'(bus.clr_en | bus.run_en), 32'd0);
    tick();
    check("run_en_first", 32'(bus.run_en), 32'd1);
    check("pc_load_drop", 32'(bus.pc_load), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.prog_sel = 2'd0;
    bus.done_instr = 1'b0; bus.branch_taken = 1'b0;
    repeat (2) tick();
    check("rst_run_en", 32'(bus.run_en), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_clr_en", 32'(bus.clr_en), 32'd0);
    check("rst_cycles", 32'(bus.cycle_count), 32'd0);
    check("rst_pc_value", bus.pc_load_value, 32'd0);
    reset = 1'b1;
    tick();

    // Run 1: prog_sel=2, done on RUN cycle 10.
    start_run(3, 2'd2, 32'd40);
    for (int k = 1; k <= 10; k++) begin
      check("run1_en", 32'(bus.run_en), 32'd1);
      bus.done_instr = (k == 10);
      tick();
    end
    bus.done_instr = 1'b0;
    check("run1_ack", 32'(bus.ack), 32'd1);
    check("run1_timeout", 32'(bus.timeout), 32'd0);
    check("run1_cycles", 32'(bus.cycle_count), 32'd10);
    check("run1_run_en", 32'(bus.run_en), 32'd0);
    check("run1_pc_hold", bus.pc_load_value, 32'd40);
    for (int k = 0; k < 20; k++) begin
      bus.done_instr = k[0];  // ignored outside RUN
      tick();
      check("run1_ack_hold", 32'(bus.ack), 32'd1);
      check("run1_cnt_frozen", 32'(bus.cycle_count), 32'd10);
    end
    bus.done_instr = 1'b0;

    // Run 2: prog_sel=1, no done -> timeout after 16 cycles.
    start_run(1, 2'd1, 32'd100);
    for (int k = 1; k <= 16; k++) begin
      check("run2_en", 32'(bus.run_en), 32'd1);
      tick();
    end
    check("run2_ack", 32'(bus.ack), 32'd1);
    check("run2_timeout", 32'(bus.timeout), 32'd1);
    check("run2_cycles", 32'(bus.cycle_count), 32'd16);

    // Run 3: done on cycle 16 coincides with limit -> done wins.
    start_run(1, 2'd0, 32'd7);
    for (int k = 1; k <= 16; k++) begin
      bus.done_instr = (k == 16);
      tick();
    end
    bus.done_instr = 1'b0;
    check("run3_ack", 32'(bus.ack), 32'd1);
    check("run3_timeout", 32'(bus.timeout), 32'd0);
    check("run3_cycles", 32'(bus.cycle_count), 32'd16);

    // Run 4: abort on RUN cycle 5.
    start_run(1, 2'd3, 32'd3);
    repeat (4) tick();
    check("run4_cycles_4", 32'(bus.cycle_count), 32'd4);
    bus.start = 1'b1;
    tick();
    check("abort_ack", 32'(bus.ack), 32'd0);
    check("abort_run_en", 32'(bus.run_en), 32'd0);
    check("abort_cycles", 32'(bus.cycle_count), 32'd0);

    // Run 5: restarted run, 12 cycles, branches on cycles 2, 5, 9.
    start_run(1, 2'd2, 32'd40);
    for (int k = 1; k <= 12; k++) begin
      bus.branch_taken = (k == 2) || (k == 5) || (k == 9);
      bus.done_instr   = (k == 12);
      tick();
    end
    bus.done_instr   = 1'b0;
    bus.branch_taken = 1'b1;  // must not count in FINISH
    repeat (2) tick();
    bus.branch_taken = 1'b0;
    check("run5_ack", 32'(bus.ack), 32'd1);
    check("run5_cycles", 32'(bus.cycle_count), 32'd12);
    check("run5_instr", 32'(bus.instr_count), EXP_INSTR);
    check("run5_branch", 32'(bus.branch_count), EXP_BR);

    // Run 6: asynchronous reset mid-RUN.
    start_run(1, 2'd1, 32'd100);
    repeat (8) tick();
    check("run6_cycles_8", 32'(bus.cycle_count), 32'd8);
    reset = 1'b0;
    #1;
    check("arst_run_en", 32'(bus.run_en), 32'd0);
    check("arst_cycles", 32'(bus.cycle_count), 32'd0);
    check("arst_pc_value", bus.pc_load_value, 32'd0);
    tick();
    check("arst_edge_run_en", 32'(bus.run_en), 32'd0);
    check("arst_edge_ack", 32'(bus.ack), 32'd0);
    check("arst_edge_cycles", 32'(bus.cycle_count), 32'd0);
    reset = 1'b1;
    bus.start = 1'b0;
    tick();
    check("idle_after_reset", 32'(bus.clr_en | bus.pc_load | bus.run_en | bus.ack), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
